// File: rtl/rx_watchdog_ctrl.sv
// rx_watchdog_ctrl: supervisory watchdog for the UART receive core.
// Watches the one-hot Rx state vector for stalled bits (no end-of-bit strobe
// within the allowed tick budget) and for illegal state vectors. On a fault it
// pulses a bounded active-low reset to the Rx core and then waits for the core
// to report INTERVAL. If the core does not return in time, it is reset again.
// Sticky fault flags and a saturating event counter feed the CSR block.
// DbgState_o exposes the controller state: 0 DISABLED, 1 MONITOR, 2 RECOVER, 3 GUARD.
module rx_watchdog_ctrl #(
    parameter int TICKS_PER_BIT  = 16,
    parameter int TIMEOUT_BITS   = 2,
    parameter int RECOVER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             AcqSig_i,
    input  logic [4:0]       RxState_i,
    input  logic             Bit_Synch_i,
    input  logic             p_WdgEnable_i,
    input  logic             p_Clear_i,
    output logic             RxCoreRstn_o,
    output logic             p_TimeoutFlag_o,
    output logic             p_IllegalFlag_o,
    output logic [CNT_W-1:0] FaultCount_o,
    output logic             p_Busy_o,
    output logic [1:0]       DbgState_o
);

    localparam int LIMIT  = TICKS_PER_BIT * TIMEOUT_BITS;
    localparam int TICK_W = $clog2(LIMIT + 1);
    localparam int REC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(LIMIT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [REC_W-1:0]  REC_LAST    = REC_W'(RECOVER_CYCLES - 1);
    localparam logic [REC_W-1:0]  REC_ONE     = REC_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [4:0]        ST_INTERVAL = 5'b00001;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_MONITOR  = 2'd1,
        S_RECOVER  = 2'd2,
        S_GUARD    = 2'd3
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [REC_W-1:0]    r_rec_cnt;
    logic                r_guard_cnt;
    logic [4:0]          r_prev_state;
    logic                r_illegal_d;
    logic                r_rstn;
    logic                r_busy;
    logic                r_tflag;
    logic                r_iflag;
    logic [CNT_W-1:0]    r_fault_cnt;

    logic w_onehot;
    logic w_illegal;
    logic w_is_interval;
    logic w_tick_clr;
    logic w_timeout;
    logic w_set_timeout;
    logic w_set_illegal;
    logic w_event;

    // Fault qualification; a fault only counts in MONITOR (or GUARD expiry)
    // and only while the watchdog is enabled, since disable takes priority.
    assign w_onehot      = (RxState_i != 5'd0) && ((RxState_i & (RxState_i - 5'd1)) == 5'd0);
    assign w_illegal     = ~w_onehot;
    assign w_is_interval = (RxState_i == ST_INTERVAL);
    assign w_tick_clr    = w_is_interval | Bit_Synch_i | (RxState_i != r_prev_state);
    assign w_timeout     = AcqSig_i & ~Bit_Synch_i & ~w_is_interval & (r_tick_cnt == TICK_LAST);
    assign w_set_timeout = (r_state == S_MONITOR) & p_WdgEnable_i & w_timeout;
    assign w_set_illegal = ((r_state == S_MONITOR) & p_WdgEnable_i & w_illegal & r_illegal_d)
                         | ((r_state == S_GUARD) & p_WdgEnable_i & ~w_is_interval & r_guard_cnt);
    assign w_event       = w_set_timeout | w_set_illegal;

    // Controller FSM with registered reset request and busy indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_DISABLED;
            r_tick_cnt   <= '0;
            r_rec_cnt    <= '0;
            r_guard_cnt  <= 1'b0;
            r_prev_state <= ST_INTERVAL;
            r_illegal_d  <= 1'b0;
            r_rstn       <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_prev_state <= RxState_i;
            case (r_state)
                S_DISABLED: begin
                    r_tick_cnt  <= '0;
                    r_illegal_d <= 1'b0;
                    r_rstn      <= 1'b1;
                    r_busy      <= 1'b0;
                    if (p_WdgEnable_i) begin
                        r_state <= S_MONITOR;
                    end
                end
                S_MONITOR: begin
                    if (!p_WdgEnable_i) begin
                        r_state     <= S_DISABLED;
                        r_tick_cnt  <= '0;
                        r_illegal_d <= 1'b0;
                    end else if (w_event) begin
                        r_state     <= S_RECOVER;
                        r_rstn      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_rec_cnt   <= '0;
                        r_tick_cnt  <= '0;
                        r_illegal_d <= 1'b0;
                    end else begin
                        r_illegal_d <= w_illegal;
                        if (w_tick_clr) begin
                            r_tick_cnt <= '0;
                        end else if (AcqSig_i) begin
                            r_tick_cnt <= r_tick_cnt + TICK_ONE;
                        end
                    end
                end
                S_RECOVER: begin
                    // The pulse always runs its full length, even if disabled midway.
                    if (r_rec_cnt == REC_LAST) begin
                        r_rstn <= 1'b1;
                        if (p_WdgEnable_i) begin
                            r_state     <= S_GUARD;
                            r_guard_cnt <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= S_DISABLED;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_rec_cnt <= r_rec_cnt + REC_ONE;
                    end
                end
                S_GUARD: begin
                    if (!p_WdgEnable_i) begin
                        r_state <= S_DISABLED;
                        r_busy  <= 1'b0;
                    end else if (w_is_interval) begin
                        r_state    <= S_MONITOR;
                        r_busy     <= 1'b0;
                        r_tick_cnt <= '0;
                    end else if (r_guard_cnt) begin
                        r_state   <= S_RECOVER;
                        r_rstn    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_rec_cnt <= '0;
                    end else begin
                        r_guard_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_DISABLED;
                    r_rstn  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags and saturating event counter; a new event overrides a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tflag     <= 1'b0;
            r_iflag     <= 1'b0;
            r_fault_cnt <= '0;
        end else begin
            if (p_Clear_i) begin
                r_tflag     <= 1'b0;
                r_iflag     <= 1'b0;
                r_fault_cnt <= '0;
            end
            if (w_set_timeout) begin
                r_tflag <= 1'b1;
            end
            if (w_set_illegal) begin
                r_iflag <= 1'b1;
            end
            if (w_event) begin
                if (p_Clear_i) begin
                    r_fault_cnt <= CNT_ONE;
                end else if (r_fault_cnt != CNT_MAX) begin
                    r_fault_cnt <= r_fault_cnt + CNT_ONE;
                end
            end
        end
    end

    assign RxCoreRstn_o    = r_rstn;
    assign p_TimeoutFlag_o = r_tflag;
    assign p_IllegalFlag_o = r_iflag;
    assign FaultCount_o    = r_fault_cnt;
    assign p_Busy_o        = r_busy;
    assign DbgState_o      = r_state;

endmodule

// File: doc/rx_watchdog_ctrl.md
# rx_watchdog_ctrl

Supervisory controller for the UART receive core. It watches the one-hot Rx state vector and the bit-synch strobe, measures time spent in each non-idle state in acquisition ticks, and detects two faults: a stalled bit and an illegal (non-one-hot) state vector. On either fault it issues a bounded reset pulse to the Rx core and confirms that the core has returned to INTERVAL. It sits beside the Rx core, with its fault status routed to the control/status register block.

## Interface
Parameters:
- TICKS_PER_BIT, 16, acquisition ticks per bit time (16x oversampling)
- TIMEOUT_BITS, 2, bit times allowed without Bit_Synch_i before timeout
- RECOVER_CYCLES, 4, clk cycles the recovery reset is held low (≥1)
- CNT_W, 8, width of the fault event counter

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-low reset
- AcqSig_i  in  1  acquisition tick from the baudrate generator, one clk wide
- RxState_i  in  5  Rx core state: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
- Bit_Synch_i  in  1  end-of-bit strobe from the Rx shift register
- p_WdgEnable_i  in  1  watchdog enable from the control register
- p_Clear_i  in  1  synchronous clear of the sticky flags and the counter
- RxCoreRstn_o  out  1  active-low reset request to the Rx core, registered
- p_TimeoutFlag_o  out  1  sticky flag: stall timeout occurred
- p_IllegalFlag_o  out  1  sticky flag: illegal state vector occurred
- FaultCount_o  out  CNT_W  saturating count of recovery events
- p_Busy_o  out  1  high while in RECOVER or GUARD

## Operation
- Derived limit: L = TICKS_PER_BIT*TIMEOUT_BITS. The tick counter width is clog2(L+1), so the default is 6 bits.
- **Controller states:** DISABLED, MONITOR, RECOVER, GUARD.
- **DISABLED:**
  - Tick counter held at 0; RxCoreRstn_o=1.
  - Goes to MONITOR when p_WdgEnable_i=1.
- **MONITOR, tick counter:**
  - Cleared when RxState_i==INTERVAL, when Bit_Synch_i=1, or when RxState_i differs from its value in the previous cycle.
  - Otherwise increments on AcqSig_i.
- **MONITOR, timeout:**
  - Condition: AcqSig_i=1, Bit_Synch_i=0, RxState_i≠INTERVAL and counter==L-1.
  - Action: set p_TimeoutFlag_o and go to RECOVER.
- **MONITOR, illegal state:**
  - Condition: RxState_i not one-hot (zero or ≥2 bits set) for 2 consecutive cycles.
  - Action: set p_IllegalFlag_o and go to RECOVER.
  - A single-cycle glitch is ignored.
- **Fault priority:** if both faults occur in the same cycle, set both flags; this counts as one event.
- **RECOVER:**
  - RxCoreRstn_o=0 for exactly RECOVER_CYCLES cycles, then go to GUARD.
- **GUARD:**
  - RxCoreRstn_o=1.
  - If RxState_i==INTERVAL within 2 cycles, go to MONITOR with the tick counter at 0.
  - Otherwise re-enter RECOVER; this counts as a new event and sets p_IllegalFlag_o.
- **FaultCount_o:**
  - +1 on every entry to RECOVER.
  - Saturates at 2^CNT_W-1.
- **p_Clear_i:**
  - Clears both flags and the counter.
  - If it coincides with a new event, the event wins: the relevant flag is set and the counter is loaded with 1.
- **Disable mid-operation:**
  - p_WdgEnable_i=0 in MONITOR or GUARD goes to DISABLED next cycle.
  - In RECOVER the pulse always completes its full RECOVER_CYCLES, then goes to DISABLED.
  - Flags and counter are retained in DISABLED.

## Timing
- **Reset values:** controller in DISABLED, tick counter 0, RxCoreRstn_o=1, both flags 0, FaultCount_o=0, p_Busy_o=0.
- **Timeout latency:** RxCoreRstn_o falls 1 clk after the qualifying AcqSig_i cycle. Flags and counter update in the same edge.
- **Illegal-state latency:** RxCoreRstn_o falls 1 clk after the second consecutive illegal cycle.
- **p_Busy_o:** registered; it equals (state==RECOVER or GUARD).
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Test plan
- **Normal frames:** p_WdgEnable_i=1, 10 clean 8N1 frames with Bit_Synch_i every 16 ticks → RxCoreRstn_o stays 1, flags 0, FaultCount_o=0.
- **Stall in DATABITS:** hold RxState_i=00100 with no Bit_Synch_i for 32 AcqSig_i ticks → RxCoreRstn_o low 1 clk after the 32nd tick for 4 cycles. Then return INTERVAL → p_TimeoutFlag_o=1, FaultCount_o=1, back in MONITOR. A Bit_Synch_i at tick 31 instead produces no timeout.
- **Illegal state vector:** RxState_i=00000 for 1 cycle → no action. RxState_i=00110 for 2 cycles → p_IllegalFlag_o=1, 4-cycle reset pulse.
- **Stuck core:** keep RxState_i=01000 through GUARD → a second RECOVER follows, FaultCount_o=2, p_IllegalFlag_o=1.
- **Clear vs event, and saturation:** p_Clear_i asserted in the same cycle as a timeout → p_TimeoutFlag_o=1, FaultCount_o=1. With CNT_W=2, 5 events → FaultCount_o=3.
- **Disable and reset mid-operation:** p_WdgEnable_i=0 at RECOVER cycle 2 → pulse still lasts 4 cycles, then DISABLED. rst=0 during RECOVER → RxCoreRstn_o=1 immediately and all outputs at reset values.
